// File: rtl/lpc_tpm_reg_arbiter_pkg.sv
// Shared encodings for the LPC/MCU register-bank arbiter: FSM states, owner codes, error fill.
package lpc_tpm_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        LPC_ARB_ST_IDLE    = 2'd0,
        LPC_ARB_ST_LPC_ACC = 2'd1,
        LPC_ARB_ST_MCU_ACC = 2'd2,
        LPC_ARB_ST_RESP    = 2'd3
    } lpc_arb_state_e;

    localparam logic LPC_ARB_OWNER_LPC = 1'b0;
    localparam logic LPC_ARB_OWNER_MCU = 1'b1;

    // Read data returned on a watchdog abort is this bit replicated across the bus.
    localparam logic LPC_ARB_ERR_FILL_BIT = 1'b1;

    localparam int LPC_ARB_STARVE_W = 4;

endpackage

// File: rtl/lpc_arb_wdt.sv
// Down-counting access watchdog: reloads on clr, counts while en, expire at terminal count.
module lpc_arb_wdt #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= CW'(LIMIT - 1);
        end else if (clr) begin
            cnt_q <= CW'(LIMIT - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/lpc_tpm_reg_arbiter.sv
// Arbitrates the TPM register-bank port between the LPC FSM and the MCU bus.
// Optional downstream watchdog enabled by defining LPC_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no access in flight; grant decision each cycle
// LPC_ACC | LPC access presented on reg_*, waiting for reg_ack_i
// MCU_ACC | MCU access presented on reg_*, waiting for reg_ack_i
// RESP    | one-cycle completion pulse to the owning requester
module lpc_tpm_reg_arbiter
    import lpc_tpm_reg_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int MCU_STARVE_MAX = 4,
    parameter int TIMEOUT_CYC    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lpc_req_i,
    input  logic              lpc_wr_i,
    input  logic [ADDR_W-1:0] lpc_addr_i,
    input  logic [DATA_W-1:0] lpc_wdata_i,
    output logic              lpc_ack_o,
    output logic [DATA_W-1:0] lpc_rdata_o,
    output logic              lpc_err_o,
    input  logic              mcu_req_i,
    input  logic              mcu_wr_i,
    input  logic [ADDR_W-1:0] mcu_addr_i,
    input  logic [DATA_W-1:0] mcu_wdata_i,
    output logic              mcu_ack_o,
    output logic [DATA_W-1:0] mcu_rdata_o,
    output logic              mcu_err_o,
    output logic              reg_req_o,
    output logic              reg_wr_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    input  logic              reg_ack_i,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              owner_o,
    output logic              busy_o
);

    localparam logic [LPC_ARB_STARVE_W-1:0] STARVE_MAX = LPC_ARB_STARVE_W'(MCU_STARVE_MAX);

    lpc_arb_state_e              state_q, state_d;
    logic [LPC_ARB_STARVE_W-1:0] starve_q, starve_d;
    logic                        owner_q, owner_d;
    logic                        reg_req_q, reg_req_d;
    logic                        reg_wr_q, reg_wr_d;
    logic [ADDR_W-1:0]           reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]           reg_wdata_q, reg_wdata_d;
    logic                        lpc_ack_q, lpc_ack_d, mcu_ack_q, mcu_ack_d;
    logic [DATA_W-1:0]           lpc_rdata_q, lpc_rdata_d, mcu_rdata_q, mcu_rdata_d;
    logic                        lpc_err_q, lpc_err_d, mcu_err_q, mcu_err_d;
    logic                        busy_q, busy_d;
    logic                        lpc_win, in_acc, wdt_expire;
    logic [DATA_W-1:0]           rsp_data;
    logic                        rsp_err;

    // MCU is forced only once LPC has won MCU_STARVE_MAX times in a row over it.
    assign lpc_win = lpc_req_i && !(mcu_req_i && (starve_q == STARVE_MAX));
    assign in_acc  = (state_q == LPC_ARB_ST_LPC_ACC) || (state_q == LPC_ARB_ST_MCU_ACC);

`ifdef LPC_ARB_TIMEOUT_EN
    lpc_arb_wdt #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wdt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (!in_acc),
        .en    (in_acc),
        .expire(wdt_expire)
    );
`else
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        reg_req_d   = reg_req_q;
        reg_wr_d    = reg_wr_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        lpc_ack_d   = 1'b0;
        mcu_ack_d   = 1'b0;
        lpc_rdata_d = lpc_rdata_q;
        mcu_rdata_d = mcu_rdata_q;
        lpc_err_d   = lpc_err_q;
        mcu_err_d   = mcu_err_q;
        rsp_data    = '0;
        rsp_err     = 1'b0;

        case (state_q)
            LPC_ARB_ST_IDLE: begin
                if (lpc_win) begin
                    state_d     = LPC_ARB_ST_LPC_ACC;
                    owner_d     = LPC_ARB_OWNER_LPC;
                    reg_req_d   = 1'b1;
                    reg_wr_d    = lpc_wr_i;
                    reg_addr_d  = lpc_addr_i;
                    reg_wdata_d = lpc_wdata_i;
                    if (mcu_req_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (mcu_req_i) begin
                    state_d     = LPC_ARB_ST_MCU_ACC;
                    owner_d     = LPC_ARB_OWNER_MCU;
                    reg_req_d   = 1'b1;
                    reg_wr_d    = mcu_wr_i;
                    reg_addr_d  = mcu_addr_i;
                    reg_wdata_d = mcu_wdata_i;
                    starve_d    = '0;
                end
            end
            LPC_ARB_ST_LPC_ACC, LPC_ARB_ST_MCU_ACC: begin
                if (reg_ack_i || wdt_expire) begin
                    state_d   = LPC_ARB_ST_RESP;
                    reg_req_d = 1'b0;
                    // A bank ack in the expiry cycle still completes normally.
                    if (reg_ack_i) begin
                        rsp_data = reg_wr_q ? '0 : reg_rdata_i;
                        rsp_err  = 1'b0;
                    end else begin
                        rsp_data = {DATA_W{LPC_ARB_ERR_FILL_BIT}};
                        rsp_err  = 1'b1;
                    end
                    if (state_q == LPC_ARB_ST_MCU_ACC) begin
                        mcu_ack_d   = 1'b1;
                        mcu_rdata_d = rsp_data;
                        mcu_err_d   = rsp_err;
                    end else begin
                        lpc_ack_d   = 1'b1;
                        lpc_rdata_d = rsp_data;
                        lpc_err_d   = rsp_err;
                    end
                end
            end
            LPC_ARB_ST_RESP: state_d = LPC_ARB_ST_IDLE;
            default:         state_d = LPC_ARB_ST_IDLE;
        endcase

        busy_d = (state_d != LPC_ARB_ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= LPC_ARB_ST_IDLE;
            starve_q    <= '0;
            owner_q     <= LPC_ARB_OWNER_LPC;
            reg_req_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            lpc_ack_q   <= 1'b0;
            mcu_ack_q   <= 1'b0;
            lpc_rdata_q <= '0;
            mcu_rdata_q <= '0;
            lpc_err_q   <= 1'b0;
            mcu_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            reg_req_q   <= reg_req_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            lpc_ack_q   <= lpc_ack_d;
            mcu_ack_q   <= mcu_ack_d;
            lpc_rdata_q <= lpc_rdata_d;
            mcu_rdata_q <= mcu_rdata_d;
            lpc_err_q   <= lpc_err_d;
            mcu_err_q   <= mcu_err_d;
            busy_q      <= busy_d;
        end
    end

    assign lpc_ack_o   = lpc_ack_q;
    assign lpc_rdata_o = lpc_rdata_q;
    assign lpc_err_o   = lpc_err_q;
    assign mcu_ack_o   = mcu_ack_q;
    assign mcu_rdata_o = mcu_rdata_q;
    assign mcu_err_o   = mcu_err_q;
    assign reg_req_o   = reg_req_q;
    assign reg_wr_o    = reg_wr_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy_q;

endmodule
